// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage pipeline core.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CTRL_W-1:0]     ctrl_t;

    localparam word_t STACK_ADDRESS = 32'h0000_3FFC;
    localparam word_t MMIO_ADDRESS  = 32'h0000_8000;

    // A source operand depends on a writer when the instruction really reads it,
    // it is not x0, and the writer is live and targets the same register.
    function automatic logic reg_match(input reg_addr_t rs, input logic en,
                                       input logic wr_valid, input reg_addr_t rd);
        return en && (rs != '0) && wr_valid && (rs == rd);
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Per-operand hazard detection and bypass selection (one instance per source).
// Build option: IDEX_FWD_EN enables the EX/MEM and WB bypass muxes; without it
// the operand always comes from the register file and any in-flight writer stalls.
module operand_forward
    import cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  en,
    input  logic [XLEN-1:0]       rf_rdata,
    input  logic                  ex_wr_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  mem_wr_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_is_load,
    input  logic [XLEN-1:0]       mem_wdata,
    input  logic                  wb_wr_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_wdata,
    output logic [XLEN-1:0]       operand,
    output logic                  fwd_hit,
    output logic                  stall
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(rs, en, ex_wr_valid, ex_rd);
    assign mem_match = reg_match(rs, en, mem_wr_valid, mem_rd);

`ifdef IDEX_FWD_EN
    logic wb_match;

    assign wb_match = reg_match(rs, en, wb_wr_valid, wb_rd);

    // Only loads stall: their data is not ready in EX or EX/MEM. EX non-load
    // results are bypassed inside EX itself, so they are not our concern.
    assign stall = (ex_match && ex_is_load) || (mem_match && mem_is_load);

    // Youngest available value wins: EX/MEM ALU result, then WB, then the file.
    always_comb begin
        operand = rf_rdata;
        fwd_hit = 1'b0;
        if (rs == '0) begin
            operand = '0;
        end else if (mem_match && !mem_is_load) begin
            operand = mem_wdata;
            fwd_hit = 1'b1;
        end else if (wb_match) begin
            operand = wb_wdata;
            fwd_hit = 1'b1;
        end
    end
`else
    logic unused_taps;

    // No bypass: interlock on any pending writer ahead of us. WB is excluded
    // because its negedge write is already visible on rf_rdata.
    assign stall       = ex_match || mem_match;
    assign unused_taps = ^{ex_is_load, mem_is_load, mem_wdata, wb_wr_valid, wb_rd, wb_wdata};

    // Operand straight from the register file, x0 forced to zero.
    always_comb begin
        operand = (rs == '0) ? '0 : rf_rdata;
        fwd_hit = 1'b0;
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand fetch, RAW hazard resolution and
// registered decode fields towards EX.
// Build option: IDEX_FWD_EN selects forwarding (default build: interlock only).
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic                  mem_wr_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_is_load,
    input  logic [XLEN-1:0]       mem_wdata,
    input  logic                  wb_wr_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_wdata,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_imm,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Handshake: an instruction moves on a clock edge where valid && ready are
    // both high on that side. id_ready depends only on the hazard check and on
    // whether the EX-side slot is empty or being drained (never on id_valid or
    // flush). The EX side holds every ex_* output while ex_valid && !ex_ready.

    logic            stall_rs1;
    logic            stall_rs2;
    logic            hazard;
    logic            transfer;
    logic            ex_wr_valid;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [1:0]      fwd_hits_unused;

    assign ex_wr_valid = ex_valid && ex_reg_write;

    operand_forward u_fwd_rs1 (
        .rs           (id_rs1),
        .en           (id_rs1_en),
        .rf_rdata     (rf_rdata1),
        .ex_wr_valid  (ex_wr_valid),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_mem_read),
        .mem_wr_valid (mem_wr_valid),
        .mem_rd       (mem_rd),
        .mem_is_load  (mem_is_load),
        .mem_wdata    (mem_wdata),
        .wb_wr_valid  (wb_wr_valid),
        .wb_rd        (wb_rd),
        .wb_wdata     (wb_wdata),
        .operand      (op1),
        .fwd_hit      (fwd_hits_unused[0]),
        .stall        (stall_rs1)
    );

    operand_forward u_fwd_rs2 (
        .rs           (id_rs2),
        .en           (id_rs2_en),
        .rf_rdata     (rf_rdata2),
        .ex_wr_valid  (ex_wr_valid),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_mem_read),
        .mem_wr_valid (mem_wr_valid),
        .mem_rd       (mem_rd),
        .mem_is_load  (mem_is_load),
        .mem_wdata    (mem_wdata),
        .wb_wr_valid  (wb_wr_valid),
        .wb_rd        (wb_rd),
        .wb_wdata     (wb_wdata),
        .operand      (op2),
        .fwd_hit      (fwd_hits_unused[1]),
        .stall        (stall_rs2)
    );

    assign hazard   = stall_rs1 || stall_rs2;
    assign id_ready = !hazard && (!ex_valid || ex_ready);
    assign transfer = id_valid && id_ready;

    // Pipeline register: flush kills, a transfer loads, a drain inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_ctrl      <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (transfer) begin
            ex_valid     <= 1'b1;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_data  <= op1;
            ex_rs2_data  <= op2;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_ctrl      <= id_ctrl;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Count cycles a waiting decode instruction is held back by a RAW hazard;
    // sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
